// File: rtl/key_sync_debounce.sv
// Multi-channel key conditioner: per-channel synchroniser chain, debounce
// counter and edge detector, driving one LED per channel as a level follower
// or as a press-toggle, plus one-cycle press/release strobes.
module key_sync_debounce #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MODE            = 1,
    parameter int unsigned ACTIVE_LOW      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] led,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [N_KEYS-1:0] pressed_raw;
    logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [N_KEYS-1:0] synced;
    logic [CNT_W-1:0]  cnt_q  [N_KEYS];
    logic [CNT_W-1:0]  cnt_d  [N_KEYS];
    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] led_d;

    // Polarity fix-up happens before the synchroniser so the chain always carries "pressed".
    assign pressed_raw = key ^ {N_KEYS{INV}};
    assign synced      = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chains, one bit per channel in each stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pressed_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce decision, strobes and LED next state for every channel.
    always_comb begin
        level_d   = key_level;
        press_d   = '0;
        release_d = '0;
        led_d     = led;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != key_level[i]) begin
                // Counter holds the number of mismatching edges already seen, so it
                // never reaches DEBOUNCE_CYCLES and cannot wrap.
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = synced[i];
                    press_d[i]   = synced[i];
                    release_d[i] = ~synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (MODE == 0) begin
                led_d[i] = level_d[i];
            end else if (press_d[i]) begin
                led_d[i] = ~led[i];
            end
        end
    end

    // Debounce state and registered outputs; reset wins over any acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            key_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            led           <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            led           <= led_d;
        end
    end

endmodule

// File: tb/tb_key_sync_debounce.sv
// Bench for key_sync_debounce: two instances (default toggle mode, and an
// active-low level-follower with different depths) checked every edge against
// a window-based reference model of the debounce rules.
module tb_key_sync_debounce;

    localparam int N    = 4;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key;
    logic [N-1:0] a_led, a_level, a_press, a_rel;
    logic [N-1:0] b_led, b_level, b_press, b_rel;

    key_sync_debounce dut_a (
        .clk           (clk),
        .reset         (reset),
        .key           (key),
        .led           (a_led),
        .key_level     (a_level),
        .press_pulse   (a_press),
        .release_pulse (a_rel)
    );

    key_sync_debounce #(
        .N_KEYS          (4),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (3),
        .MODE            (0),
        .ACTIVE_LOW      (1)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .key           (key),
        .led           (b_led),
        .key_level     (b_level),
        .press_pulse   (b_press),
        .release_pulse (b_rel)
    );

    always #5 clk = ~clk;

    // Per-instance parameters seen by the model.
    int s_p    [2] = '{2, 3};
    int d_p    [2] = '{4, 3};
    int mode_p [2] = '{1, 0};
    bit al_p   [2] = '{1'b0, 1'b1};

    logic [N-1:0] key_hist [MAXE];
    bit           rst_hist [MAXE];
    logic [N-1:0] m_level [2];
    logic [N-1:0] m_press [2];
    logic [N-1:0] m_rel   [2];
    logic [N-1:0] m_led   [2];
    int           last_ev [2][N];
    int           edge_n = 0;
    int           checks = 0;
    int           errors = 0;

    // Pressed value the debouncer of instance inst looks at on edge e: the pin
    // as sampled SYNC_STAGES edges earlier, or 0 if a reset flushed the chain since.
    function automatic bit used_bit(int inst, int e, int ch);
        int s = s_p[inst];
        if (e - s < 0) return 1'b0;
        for (int k = e - s; k < e; k++) begin
            if (rst_hist[k]) return 1'b0;
        end
        return key_hist[e-s][ch] ^ al_p[inst];
    endfunction

    // A new level is accepted when the last DEBOUNCE_CYCLES looked-at values all
    // differ from the current level and none of them precede the previous
    // acceptance or reset on that channel.
    task automatic model_edge(input int e);
        for (int inst = 0; inst < 2; inst++) begin
            if (rst_hist[e]) begin
                m_level[inst] = '0;
                m_press[inst] = '0;
                m_rel[inst]   = '0;
                m_led[inst]   = '0;
                for (int ch = 0; ch < N; ch++) last_ev[inst][ch] = e;
            end else begin
                m_press[inst] = '0;
                m_rel[inst]   = '0;
                for (int ch = 0; ch < N; ch++) begin
                    bit u;
                    bit ok;
                    u  = used_bit(inst, e, ch);
                    ok = (e - d_p[inst] + 1 > last_ev[inst][ch]);
                    for (int k = 0; k < d_p[inst]; k++) begin
                        if (used_bit(inst, e - k, ch) != u) ok = 1'b0;
                    end
                    if (ok && u != m_level[inst][ch]) begin
                        m_level[inst][ch] = u;
                        last_ev[inst][ch] = e;
                        if (u) begin
                            m_press[inst][ch] = 1'b1;
                            if (mode_p[inst] == 1) m_led[inst][ch] = ~m_led[inst][ch];
                        end else begin
                            m_rel[inst][ch] = 1'b1;
                        end
                    end
                    if (mode_p[inst] == 0) m_led[inst][ch] = m_level[inst][ch];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge %0d observed %b expected %b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("a_level", a_level, m_level[0]);
        chk("a_press", a_press, m_press[0]);
        chk("a_release", a_rel, m_rel[0]);
        chk("a_led", a_led, m_led[0]);
        chk("b_level", b_level, m_level[1]);
        chk("b_press", b_press, m_press[1]);
        chk("b_release", b_rel, m_rel[1]);
        chk("b_led", b_led, m_led[1]);
    endtask

    // Drive inputs for the next edge, let it happen, update model, compare.
    task automatic step(input logic [N-1:0] k, input bit r);
        key   = k;
        reset = r;
        @(posedge clk);
        key_hist[edge_n] = k;
        rst_hist[edge_n] = r;
        model_edge(edge_n);
        #1;
        compare_all();
        edge_n++;
    endtask

    task automatic hold(input logic [N-1:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    initial begin
        logic [N-1:0] kv;
        for (int inst = 0; inst < 2; inst++) begin
            m_level[inst] = '0;
            m_press[inst] = '0;
            m_rel[inst]   = '0;
            m_led[inst]   = '0;
            for (int ch = 0; ch < N; ch++) last_ev[inst][ch] = 0;
        end

        // Keys held pressed through reset: outputs zero during reset, then one press each.
        step(4'b1111, 1'b1);
        chk("reset_level", a_level, 4'b0000);
        step(4'b1111, 1'b1);
        chk("reset_led", a_led, 4'b0000);
        hold(4'b1111, 5);
        step(4'b1111, 1'b0);
        chk("post_reset_press", a_press, 4'b1111);
        chk("post_reset_led", a_led, 4'b1111);
        step(4'b1111, 1'b0);
        chk("post_reset_press_one_cycle", a_press, 4'b0000);
        hold(4'b1111, 10);
        hold(4'b0000, 15);

        // Clean press/release/press on ch0.
        hold(4'b0001, 20);
        hold(4'b0000, 15);
        hold(4'b0001, 20);
        hold(4'b0000, 15);

        // Bouncy press on ch1, then an isolated 3-cycle glitch.
        hold(4'b0010, 2);
        hold(4'b0000, 1);
        hold(4'b0010, 3);
        hold(4'b0000, 2);
        hold(4'b0010, 20);
        hold(4'b0000, 15);
        hold(4'b0010, 3);
        hold(4'b0000, 15);

        // ch2 pin low for 10 cycles (pressed for the active-low instance).
        hold(4'b1011, 10);
        hold(4'b1111, 15);
        hold(4'b0000, 15);

        // ch0 and ch3 together, ch2 two cycles later.
        hold(4'b1001, 2);
        hold(4'b1101, 20);
        hold(4'b0000, 15);

        // Reset in the middle of a debounce, key kept pressed.
        hold(4'b0001, 3);
        step(4'b0001, 1'b1);
        hold(4'b0001, 15);
        hold(4'b0000, 15);

        // Random bouncing keys with rare resets.
        kv = '0;
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 7) == 0) kv[ch] = ~kv[ch];
            end
            step(kv, ($urandom_range(0, 199) == 0));
        end
        hold(4'b0000, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
